// File: rtl/jtag_uart_pkg.sv
// ============================================================================
// Module      : jtag_uart_pkg
// Description : Shared register-map constants and the access state type for
//               the JTAG UART responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_uart_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd4;

  localparam int RVALID_BIT = 15;
  localparam int RAVAIL_LSB = 16;
  localparam int WSPACE_LSB = 16;
  localparam int RE_BIT     = 0;
  localparam int WE_BIT     = 1;
  localparam int RI_BIT     = 8;
  localparam int WI_BIT     = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

endpackage

`default_nettype wire

// File: rtl/jtag_uart_responder_byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : Byte-wide FIFO, 2**DEPTH_LOG2 entries, registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0]         CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  // A pop at full frees the slot the same-cycle push lands in; no bypass at empty.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/jtag_uart_responder.sv
// ============================================================================
// Module      : jtag_uart_responder
// Description : Avalon-MM JTAG UART register map backed by RX/TX byte FIFOs.
//               Define JTAG_UART_RESP_IRQ_EN to add the irq output and the
//               CONTROL interrupt enable/pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_uart_responder
  import jtag_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        host_in_canGet,
  input  logic [7:0]  host_in_getData,
  output logic        host_in_get,
  output logic        host_out_canGet,
  output logic [7:0]  host_out_getData,
  input  logic        host_out_get
`ifdef JTAG_UART_RESP_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  ack_state_e    state_q, state_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   reg_rdata;
  logic          access, is_write, tx_block;
  logic          rx_pop, tx_push;
  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          unused_wdata;

  assign access       = read | write;
  assign is_write     = write & ~read;
  assign tx_block     = is_write & (address == ADDR_DATA) & tx_full;
  assign waitrequest  = access & (state_q == ST_IDLE);
  assign readdata     = readdata_q;
  assign unused_wdata = ^writedata[31:8];

  // Pop decision uses the RVALID captured with the data, not the live count.
  assign rx_pop  = (state_q == ST_ACK) & read & (address == ADDR_DATA) & readdata_q[RVALID_BIT];
  assign tx_push = (state_q == ST_ACK) & is_write & (address == ADDR_DATA);

  assign host_in_get      = reset & host_in_canGet & (~rx_full | rx_pop);
  assign host_out_canGet  = ~tx_empty;
  assign host_out_getData = tx_head;

`ifdef JTAG_UART_RESP_IRQ_EN
  logic re_q, we_q, irq_q, ctrl_wr;

  assign ctrl_wr = (state_q == ST_ACK) & is_write & (address == ADDR_CONTROL);
  assign irq     = irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      re_q  <= 1'b0;
      we_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        re_q <= writedata[RE_BIT];
        we_q <= writedata[WE_BIT];
      end
      irq_q <= (re_q & ~rx_empty) | (we_q & tx_empty);
    end
  end
`endif

  always_comb begin
    reg_rdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!rx_empty) begin
          reg_rdata[7:0]              = rx_head;
          reg_rdata[RVALID_BIT]       = 1'b1;
          reg_rdata[RAVAIL_LSB +: 16] = 16'(rx_count - CNT_ONE);
        end
      end
      ADDR_CONTROL: begin
        reg_rdata[WSPACE_LSB +: 16] = 16'(DEPTH_CNT - tx_count);
`ifdef JTAG_UART_RESP_IRQ_EN
        reg_rdata[RE_BIT] = re_q;
        reg_rdata[WE_BIT] = we_q;
        reg_rdata[RI_BIT] = re_q & ~rx_empty;
        reg_rdata[WI_BIT] = we_q & tx_empty;
`endif
      end
      default: reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          readdata_d = reg_rdata;
          if (!tx_block) state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
    end
  end

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_in_get),
    .push_data (host_in_getData),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (writedata[7:0]),
    .pop       (host_out_get),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_jtag_uart_responder.sv
// ============================================================================
// Module      : tb_jtag_uart_responder
// Description : Randomised scoreboard bench for jtag_uart_responder; honours
//               JTAG_UART_RESP_IRQ_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_uart_responder;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        host_in_canGet = 1'b0;
  logic [7:0]  host_in_getData = '0;
  logic        host_in_get;
  logic        host_out_canGet;
  logic [7:0]  host_out_getData;
  logic        host_out_get = 1'b0;
`ifdef JTAG_UART_RESP_IRQ_EN
  logic        irq;
`endif

  jtag_uart_responder #(.DEPTH_LOG2(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .address          (address),
    .writedata        (writedata),
    .write            (write),
    .read             (read),
    .waitrequest      (waitrequest),
    .readdata         (readdata),
    .host_in_canGet   (host_in_canGet),
    .host_in_getData  (host_in_getData),
    .host_in_get      (host_in_get),
    .host_out_canGet  (host_out_canGet),
    .host_out_getData (host_out_getData),
    .host_out_get     (host_out_get)
`ifdef JTAG_UART_RESP_IRQ_EN
    ,
    .irq              (irq)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: byte queues plus interrupt enables.
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  bit          re_m, we_m, irq_m;

  int  total = 0;
  int  bad   = 0;
  bit  completing = 0;
  bit  snap_rv = 0;
  bit  host_in_en = 0, host_out_en = 0, force_in = 0;
  int  in_rate = 0, out_rate = 0;
  int  blk_release = -1;
  int  last_blocked = 0;
  logic [7:0] force_byte = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 3'd0) begin
      if (rx_q.size() != 0) v = {16'(rx_q.size() - 1), 1'b1, 7'd0, rx_q[0]};
    end else if (a == 3'd4) begin
      v[31:16] = 16'(DEPTH - tx_q.size());
`ifdef JTAG_UART_RESP_IRQ_EN
      v[0] = re_m;
      v[1] = we_m;
      v[8] = re_m && (rx_q.size() != 0);
      v[9] = we_m && (tx_q.size() == 0);
`endif
    end
    return v;
  endfunction

  task automatic host_drive();
    if (force_in) begin
      host_in_canGet  = 1'b1;
      host_in_getData = force_byte;
    end else begin
      host_in_canGet  = host_in_en && ($urandom_range(0, 99) < in_rate);
      host_in_getData = 8'($urandom);
    end
    host_out_get = host_out_en && (tx_q.size() != 0) && ($urandom_range(0, 99) < out_rate);
  endtask

  // One clock: drive host side, check combinational outputs, advance the model.
  task automatic tick();
    bit rxpop, rxpush, txpush, txpop, ctrlwr, irq_n;
    host_drive();
    rxpop  = completing && read && (address == 3'd0) && snap_rv;
    txpush = completing && write && !read && (address == 3'd0);
    ctrlwr = completing && write && !read && (address == 3'd4);
    txpop  = host_out_get;
    rxpush = host_in_canGet && ((rx_q.size() < DEPTH) || rxpop);
    #2;
    chk("waitrequest", {31'd0, waitrequest}, {31'd0, (read || write) && !completing});
    chk("host_in_get", {31'd0, host_in_get}, {31'd0, rxpush});
    chk("host_out_canGet", {31'd0, host_out_canGet}, {31'd0, tx_q.size() != 0});
    @(posedge clock);
    irq_n = (re_m && rx_q.size() != 0) || (we_m && tx_q.size() == 0);
    irq_m = irq_n;
    if (rxpop)  void'(rx_q.pop_front());
    if (rxpush) rx_q.push_back(host_in_getData);
    if (txpop)  void'(tx_q.pop_front());
    if (txpush) tx_q.push_back(writedata[7:0]);
`ifdef JTAG_UART_RESP_IRQ_EN
    if (ctrlwr) begin
      re_m = writedata[0];
      we_m = writedata[1];
    end
`else
    if (ctrlwr) begin
      re_m = 1'b0;
      we_m = 1'b0;
    end
`endif
    #1;
  endtask

  task automatic idle(input int n);
    read = 0; write = 0; completing = 0;
    repeat (n) tick();
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] wd);
    int g;
    g = 0;
    read = rd; write = wr; address = a; writedata = wd; completing = 0;
    while (wr && !rd && a == 3'd0 && tx_q.size() == DEPTH) begin
      if (g == blk_release) begin
        host_out_en = 1; out_rate = 100;
      end
      tick();
      g++;
      if (g > 1000) begin
        chk("tx_block_timeout", 32'd1, 32'd0);
        break;
      end
    end
    last_blocked = g;
    snap_rv = (rx_q.size() != 0);
    if (rd) exp_q.push_back(model_read(a));
    tick();
    completing = 1;
    tick();
    completing = 0; read = 0; write = 0;
  endtask

  task automatic host_push(input logic [7:0] b);
    force_in = 1; force_byte = b;
    idle(1);
    force_in = 0;
  endtask

  // Monitor: compares completed reads and host-consumed bytes against the model.
  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (reset) begin
      if (read && !waitrequest) begin
        if (exp_q.size() == 0) chk("unexpected_read", readdata, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("readdata", readdata, e);
        end
      end
      if (host_out_get && tx_q.size() != 0)
        chk("host_out_getData", {24'd0, host_out_getData}, {24'd0, tx_q[0]});
`ifdef JTAG_UART_RESP_IRQ_EN
      chk("irq", {31'd0, irq}, {31'd0, irq_m});
`endif
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int g;
    #1 reset = 0;
    read = 1; address = 3'd4; host_in_canGet = 1;
    #2;
    chk("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_host_out_canGet", {31'd0, host_out_canGet}, 32'd0);
    chk("rst_host_in_get", {31'd0, host_in_get}, 32'd0);
    host_in_canGet = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1;

    // Reset state of CONTROL.
    access(1, 0, 3'd4, 0);

    // Two host bytes then three DATA reads.
    host_push(8'h41);
    host_push(8'h42);
    repeat (3) access(1, 0, 3'd0, 0);

    // Seventeen writes with the host stalled; release after a few blocked cycles.
    host_out_en = 0;
    for (int i = 0; i < 16; i++) access(0, 1, 3'd0, {$urandom, 8'(8'h60 + i)} >> 8 << 8 | 32'(8'h60 + i));
    blk_release = 3;
    access(0, 1, 3'd0, 32'h0000_0070);
    blk_release = -1;
    chk("tx_blocked_cycles", 32'(last_blocked), 32'd4);
    g = 0;
    while (tx_q.size() != 0 && g < 200) begin idle(1); g++; end
    chk("tx_drained", 32'(tx_q.size()), 32'd0);

    // RX full, concurrent host push and DATA pop.
    host_in_en = 1; in_rate = 100;
    idle(20);
    access(1, 0, 3'd0, 0);
    access(1, 0, 3'd0, 0);
    host_in_en = 0;
    for (int i = 0; i < 17; i++) access(1, 0, 3'd0, 0);

`ifdef JTAG_UART_RESP_IRQ_EN
    access(0, 1, 3'd4, 32'h1);
    host_push(8'h55);
    idle(2);
    chk("irq_set", {31'd0, irq}, 32'd1);
    access(1, 0, 3'd0, 0);
    idle(2);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    access(0, 1, 3'd4, 32'h0);
`endif

    // Reset in the ACK cycle of a CONTROL read.
    host_in_en = 1; in_rate = 50; host_out_en = 0;
    access(0, 1, 3'd0, 32'h0000_00a5);
    read = 1; write = 0; address = 3'd4; completing = 0;
    exp_q.push_back(model_read(3'd4));
    tick();
    reset = 0;
    host_in_canGet = 1;
    #2;
    chk("midrst_waitrequest", {31'd0, waitrequest}, 32'd1);
    chk("midrst_readdata", readdata, 32'd0);
    chk("midrst_host_out_canGet", {31'd0, host_out_canGet}, 32'd0);
    chk("midrst_host_in_get", {31'd0, host_in_get}, 32'd0);
    void'(exp_q.pop_back());
    rx_q.delete(); tx_q.delete();
    re_m = 0; we_m = 0; irq_m = 0;
    @(posedge clock); #1;
    reset = 1;
    host_in_en = 0;
    access(1, 0, 3'd4, 0);
    access(1, 0, 3'd0, 0);

    // Randomised traffic.
    host_in_en = 1; in_rate = 30; host_out_en = 1; out_rate = 40;
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [2:0] ua;
      op = $urandom_range(0, 9);
      ua = 3'($urandom);
      if (ua == 3'd0 || ua == 3'd4) ua = 3'd6;
      case (op)
        0, 1, 2, 3: access(1, ($urandom_range(0, 7) == 0), 3'd0, $urandom);
        4, 5, 6:    access(0, 1, 3'd0, $urandom);
        7:          access(1, 0, 3'd4, 0);
        8:          access(0, 1, 3'd4, $urandom);
        default:    access($urandom_range(0, 1) == 1, 1, ua, $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Drain both directions.
    host_in_en = 0; host_out_en = 1; out_rate = 100;
    g = 0;
    while (rx_q.size() != 0 && g < 40) begin access(1, 0, 3'd0, 0); g++; end
    access(1, 0, 3'd0, 0);
    g = 0;
    while (tx_q.size() != 0 && g < 100) begin idle(1); g++; end
    idle(2);
    chk("rx_final_empty", 32'(rx_q.size()), 32'd0);
    chk("tx_final_empty", 32'(tx_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
